// File: rtl/jtbubl_gfx_romarb.sv
// Round-robin arbiter that lets the tile fetcher (A) and the object fetcher (B) share one SDRAM slot.
// Optional WAIT-state timeout is enabled by defining JTBUBL_ROMARB_TOUT_EN.
module jtbubl_gfx_romarb #(
  parameter int         AW   = 18,
  parameter logic [7:0] TOUT = 8'd200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_cs,
  input  logic [AW-1:0] a_addr,
  output logic [31:0]   a_data,
  output logic          a_ok,
  input  logic          b_cs,
  input  logic [AW-1:0] b_addr,
  output logic [31:0]   b_data,
  output logic          b_ok,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [31:0]   rom_data,
  input  logic          rom_ok,
  output logic          tout_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t        state;
  logic          gnt_b;   // requester owning the current transfer
  logic          last_b;  // requester served most recently
  logic          a_valid, b_valid;
  logic [AW-1:0] a_last, b_last;
  logic          a_pend, b_pend, pick_b;

  // A requester is satisfied only while it still asks for the address last delivered to it.
  assign a_ok   = a_valid & a_cs & (a_addr == a_last);
  assign b_ok   = b_valid & b_cs & (b_addr == b_last);
  assign a_pend = a_cs & ~a_ok;
  assign b_pend = b_cs & ~b_ok;
  assign pick_b = b_pend & (~a_pend | ~last_b);

`ifdef JTBUBL_ROMARB_TOUT_EN
  logic [7:0] tout_cnt;
  logic       tout_hit;
  assign tout_hit = (tout_cnt == TOUT - 8'd1);
`else
  logic unused_tout;
  assign tout_err    = 1'b0;
  assign unused_tout = ^TOUT;
`endif

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      gnt_b    <= 1'b0;
      last_b   <= 1'b1;
      // NOTE: data registers are reset too, so a_data/b_data read zero until the first transfer.
      a_data   <= '0;
      b_data   <= '0;
      a_valid  <= 1'b0;
      b_valid  <= 1'b0;
      a_last   <= '0;
      b_last   <= '0;
`ifdef JTBUBL_ROMARB_TOUT_EN
      tout_cnt <= 8'd0;
      tout_err <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (a_pend | b_pend) begin
            gnt_b    <= pick_b;
            rom_addr <= pick_b ? b_addr : a_addr;
            rom_cs   <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // rom_ok here still belongs to the previous address.
          state <= ST_WAIT;
`ifdef JTBUBL_ROMARB_TOUT_EN
          tout_cnt <= 8'd0;
`endif
        end
        ST_WAIT: begin
          if (rom_ok) begin
            if (gnt_b) begin
              b_data  <= rom_data;
              b_valid <= 1'b1;
              b_last  <= rom_addr;
            end else begin
              a_data  <= rom_data;
              a_valid <= 1'b1;
              a_last  <= rom_addr;
            end
            last_b <= gnt_b;
            rom_cs <= 1'b0;
            state  <= ST_IDLE;
          end
`ifdef JTBUBL_ROMARB_TOUT_EN
          else if (tout_hit) begin
            last_b   <= gnt_b;
            rom_cs   <= 1'b0;
            tout_err <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            tout_cnt <= tout_cnt + 8'd1;
          end
`endif
        end
        // NOTE: unreachable encoding recovers to IDLE instead of locking up.
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
